// File: rtl/speck_arbiter_if.sv
// Requester and engine signal bundle for speck_arbiter.
// master = arbiter side, slave = requesters plus engine.
interface speck_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rsp_data;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout_err;
  logic               eng_reset;
  logic               eng_start;
  logic [DW-1:0]      eng_din;
  logic               eng_done;
  logic [DW-1:0]      eng_dout;

  modport master (
    input  req, req_data, eng_done, eng_dout,
    output ack, rsp_data, grant_id, busy,
    output timeout_err, eng_reset, eng_start,
    output eng_din
  );

  modport slave (
    output req, req_data, eng_done, eng_dout,
    input  ack, rsp_data, grant_id, busy,
    input  timeout_err, eng_reset, eng_start,
    input  eng_din
  );
endinterface

// File: rtl/speck_arbiter.sv
// Round-robin sharer of one Speck engine among NREQ requesters.
// Optional WAIT watchdog: define SPECK_ARB_TIMEOUT_EN.
module speck_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  speck_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_GO   = 3'd2,
    S_WAIT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [1:0] LAST = 2'(NREQ - 1);

  state_t     state;
  logic [1:0] ptr;
  logic       lo_hit, hi_hit;
  logic [1:0] lo_win, hi_win, win;

  // Lowest requester at/after ptr, else lowest overall.
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_win = '0;
    hi_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        lo_hit = 1'b1;
        lo_win = 2'(i);
        if (2'(i) >= ptr) begin
          hi_hit = 1'b1;
          hi_win = 2'(i);
        end
      end
    end
  end

  assign win = hi_hit ? hi_win : lo_win;

`ifdef SPECK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      bus.ack      <= '0;
      bus.rsp_data <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.eng_din  <= '0;
      bus.eng_reset <= 1'b1;
`ifdef SPECK_ARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
      bus.ack       <= '0;
      bus.eng_start <= 1'b0;
`ifdef SPECK_ARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (lo_hit) begin
            state        <= S_CLR;
            bus.grant_id <= win;
            bus.eng_din  <= bus.req_data[win*DW +: DW];
            bus.busy     <= 1'b1;
          end
        end
        S_CLR: begin
          state         <= S_GO;
          bus.eng_reset <= 1'b0;
          bus.eng_start <= 1'b1;
        end
        S_GO: begin
          state <= S_WAIT;
`ifdef SPECK_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (bus.eng_done) begin
            state        <= S_RESP;
            bus.rsp_data <= bus.eng_dout;
            bus.ack      <= ONE << bus.grant_id;
          end
`ifdef SPECK_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state           <= S_RESP;
            bus.rsp_data    <= '0;
            bus.ack         <= ONE << bus.grant_id;
            bus.timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.busy      <= 1'b0;
          bus.eng_reset <= 1'b1;
          ptr <= (bus.grant_id == LAST) ? 2'd0
                                        : bus.grant_id + 2'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speck_arbiter.sv
// Directed bench for speck_arbiter with a simple engine model.
// Build with SPECK_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_speck_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  speck_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  speck_arbiter #(
    .NREQ(NREQ), .DW(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        man_done = 1'b0;
  logic        auto_done = 1'b0;
  logic        eng_auto = 1'b0;
  logic [31:0] man_dout = '0;
  logic [31:0] auto_dout = '0;
  logic [31:0] eng_key = '0;
  int          eng_lat = 3;
  int          ecnt = -1;

  assign bus.eng_done = man_done | auto_done;
  assign bus.eng_dout = man_done ? man_dout : auto_dout;

  // Engine answers eng_lat cycles after the start cycle.
  always @(posedge clk) begin
    #2;
    auto_done = 1'b0;
    if (reset || !eng_auto) begin
      ecnt = -1;
    end else begin
      if (bus.eng_start) ecnt = eng_lat;
      else if (ecnt > 0) ecnt--;
      if (ecnt == 0) begin
        auto_done = 1'b1;
        auto_dout = bus.eng_din ^ eng_key;
        ecnt = -1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == '0 && n < 40);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    man_done = 1'b0;
    eng_auto = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int hold;
    logic [1:0] seen;
    bus.req = '0;
    bus.req_data = '0;

    // reset values
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_rsp", bus.rsp_data, 32'h0);
    chk("rst_gid", 32'(bus.grant_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_start", 32'(bus.eng_start), 32'h0);
    chk("rst_din", bus.eng_din, 32'h0);
    chk("rst_ereset", 32'(bus.eng_reset), 32'h1);
    chk("rst_terr", 32'(bus.timeout_err), 32'h0);

    // single request
    eng_auto = 1'b1;
    eng_lat = 3;
    eng_key = 32'h6574694C ^ 32'hA86842F2;
    bus.req_data = {32'h0, 32'h6574694C};
    bus.req = 2'b01;
    reset = 1'b0;
    @(negedge clk);
    chk("t1_clr_ereset", 32'(bus.eng_reset), 32'h1);
    chk("t1_clr_start", 32'(bus.eng_start), 32'h0);
    chk("t1_clr_busy", 32'(bus.busy), 32'h1);
    chk("t1_din", bus.eng_din, 32'h6574694C);
    @(negedge clk);
    chk("t1_go_start", 32'(bus.eng_start), 32'h1);
    chk("t1_go_ereset", 32'(bus.eng_reset), 32'h0);
    wait_ack(n);
    chk("t1_lat", 32'(n), 32'd4);
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_rsp", bus.rsp_data, 32'hA86842F2);
    chk("t1_gid", 32'(bus.grant_id), 32'h0);
    bus.req = '0;
    @(negedge clk);
    chk("t1_ack_off", 32'(bus.ack), 32'h0);
    chk("t1_busy_off", 32'(bus.busy), 32'h0);
    chk("t1_idle_ereset", 32'(bus.eng_reset), 32'h1);

    // contention, both held
    do_reset();
    eng_auto = 1'b1;
    eng_key = 32'hFFFFFFFF;
    bus.req_data = {32'h22222222, 32'h11111111};
    bus.req = 2'b11;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n);
      chk($sformatf("t2_gid%0d", i), 32'(bus.grant_id),
          (i % 2 == 0) ? 32'h0 : 32'h1);
      chk($sformatf("t2_ack%0d", i), 32'(bus.ack),
          (i % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t2_rsp%0d", i), bus.rsp_data,
          (i % 2 == 0) ? 32'hEEEEEEEE : 32'hDDDDDDDD);
    end

    // done outside WAIT is ignored
    do_reset();
    man_dout = 32'hDEADBEEF;
    man_done = 1'b1;
    bus.req_data = {32'h0, 32'h0BADF00D};
    reset = 1'b0;
    @(negedge clk);
    bus.req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    man_done = 1'b0;
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.ack;
    end
    chk("t3_no_ack", 32'(seen), 32'h0);
    chk("t3_rsp_kept", bus.rsp_data, 32'h0);
    chk("t3_busy", 32'(bus.busy), 32'h1);
    man_dout = 32'h5A5A5A5A;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("t3_ack", 32'(bus.ack), 32'h1);
    chk("t3_rsp", bus.rsp_data, 32'h5A5A5A5A);

    // reset two cycles into WAIT
    do_reset();
    bus.req_data = {32'h13572468, 32'h0};
    bus.req = 2'b10;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_gid1", 32'(bus.grant_id), 32'h1);
    repeat (3) @(negedge clk);
    chk("t4_wait_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("t4_busy", 32'(bus.busy), 32'h0);
    chk("t4_ereset", 32'(bus.eng_reset), 32'h1);
    chk("t4_gid", 32'(bus.grant_id), 32'h0);
    chk("t4_din", bus.eng_din, 32'h0);
    chk("t4_ack", 32'(bus.ack), 32'h0);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("t4_ack_rst", 32'(bus.ack), 32'h0);
    bus.req = 2'b11;
    reset = 1'b0;
    @(negedge clk);
    chk("t4_regrant", 32'(bus.grant_id), 32'h0);

    // engine never finishes
    do_reset();
    bus.req_data = {32'h0, 32'h0F0F0F0F};
    bus.req = 2'b01;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef SPECK_ARB_TIMEOUT_EN
    wait_ack(n);
    chk("t5_lat", 32'(n), 32'd9);
    chk("t5_ack", 32'(bus.ack), 32'h1);
    chk("t5_terr", 32'(bus.timeout_err), 32'h1);
    chk("t5_rsp", bus.rsp_data, 32'h0);
    @(negedge clk);
    chk("t5_terr_off", 32'(bus.timeout_err), 32'h0);
`else
    hold = 0;
    seen = '0;
    repeat (100) begin
      @(negedge clk);
      if (bus.busy) hold++;
      seen = seen | bus.ack;
    end
    chk("t5_busy_hold", 32'(hold), 32'd100);
    chk("t5_no_ack", 32'(seen), 32'h0);
    chk("t5_terr", 32'(bus.timeout_err), 32'h0);
`endif

    // requester 1 drops right after grant
    do_reset();
    eng_auto = 1'b1;
    eng_key = 32'h0;
    bus.req_data = {32'h24682468, 32'h0};
    bus.req = 2'b10;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_gid", 32'(bus.grant_id), 32'h1);
    bus.req = '0;
    wait_ack(n);
    chk("t6_ack", 32'(bus.ack), 32'h2);
    chk("t6_rsp", bus.rsp_data, 32'h24682468);
    hold = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack != '0) hold++;
    end
    chk("t6_once", 32'(hold), 32'd0);
    chk("t6_idle", 32'(bus.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
